// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle for mux_rr_arbiter: N input channels in, one registered
// stream out. The optional packet-lock signals (Last_In/Last_Out) exist only
// when MUX_PKT_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int SEL_WIDTH    = 2
);
    logic                               Enable_In;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In;
    logic [NUM_CHANNELS-1:0]            Valid_In;
    logic [NUM_CHANNELS-1:0]            Ready_Out;
    logic [DATA_WIDTH-1:0]              Data_Out;
    logic                               Valid_Out;
    logic                               Ready_In;
    logic [SEL_WIDTH-1:0]               Select_Out;
`ifdef MUX_PKT_LOCK_EN
    logic [NUM_CHANNELS-1:0]            Last_In;
    logic                               Last_Out;

    // Arbiter side
    modport slave (
        input  Enable_In, Data_In, Valid_In, Ready_In, Last_In,
        output Ready_Out, Data_Out, Valid_Out, Select_Out, Last_Out
    );

    // Producer/consumer side
    modport master (
        output Enable_In, Data_In, Valid_In, Ready_In, Last_In,
        input  Ready_Out, Data_Out, Valid_Out, Select_Out, Last_Out
    );
`else
    // Arbiter side
    modport slave (
        input  Enable_In, Data_In, Valid_In, Ready_In,
        output Ready_Out, Data_Out, Valid_Out, Select_Out
    );

    // Producer/consumer side
    modport master (
        output Enable_In, Data_In, Valid_In, Ready_In,
        input  Ready_Out, Data_Out, Valid_Out, Select_Out
    );
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// N:1 registered round-robin multiplexer with valid/ready on every channel.
// One output register stage; a new word can be granted in the same cycle the
// held word is consumed, so throughput is one word per clock.
// Optional feature macro: MUX_PKT_LOCK_EN -- keeps the grant on one channel
// until a word flagged with Last_In has been transferred.
module mux_rr_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int SEL_WIDTH    = 2
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    mux_rr_arbiter_if.slave  bus
);
    localparam int N = NUM_CHANNELS;

    logic [DATA_WIDTH-1:0] chan_word [N];
    logic                  slot_free;
    logic                  grant_valid;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [SEL_WIDTH-1:0]  grant_next;

    logic [SEL_WIDTH-1:0]  ptr_q,   ptr_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  valid_q, valid_d;
    logic [SEL_WIDTH-1:0]  sel_q,   sel_d;
`ifdef MUX_PKT_LOCK_EN
    logic                  lock_q,    lock_d;
    logic [SEL_WIDTH-1:0]  lock_ch_q, lock_ch_d;
    logic                  last_q,    last_d;
`endif

    // The output register can take a new word when empty or being drained now.
    assign slot_free = !valid_q || bus.Ready_In;

    // Unpack channel words and drive the one-hot accept vector.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan_word[gi]     = bus.Data_In[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.Ready_Out[gi] = grant_valid && (grant_idx == SEL_WIDTH'(gi));
        end
    endgenerate

    // Grant search: first requester at or above the pointer, wrapping; a held
    // packet lock restricts the search to the locked channel.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!Reset_In && bus.Enable_In && slot_free) begin
`ifdef MUX_PKT_LOCK_EN
            if (lock_q) begin
                if (bus.Valid_In[lock_ch_q]) begin
                    grant_valid = 1'b1;
                    grant_idx   = lock_ch_q;
                end
            end else
`endif
            begin
                for (int i = 0; i < N; i++) begin
                    if (!grant_valid && bus.Valid_In[(int'(ptr_q) + i) % N]) begin
                        grant_valid = 1'b1;
                        grant_idx   = SEL_WIDTH'((int'(ptr_q) + i) % N);
                    end
                end
            end
        end
    end

    assign grant_next = (grant_idx == SEL_WIDTH'(N - 1)) ? '0 : grant_idx + 1'b1;

    // Next-state for the output register, pointer and optional lock.
    always_comb begin
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
`ifdef MUX_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        last_d    = last_q;
`endif
        if (grant_valid) begin
            // Every grant is a transfer: Ready_Out is only raised on a valid channel.
            data_d  = chan_word[grant_idx];
            sel_d   = grant_idx;
            valid_d = 1'b1;
`ifdef MUX_PKT_LOCK_EN
            last_d    = bus.Last_In[grant_idx];
            lock_ch_d = grant_idx;
            lock_d    = !bus.Last_In[grant_idx];
            if (bus.Last_In[grant_idx]) begin
                ptr_d = grant_next;
            end
`else
            ptr_d = grant_next;
`endif
        end else if (bus.Ready_In) begin
            // Drained with nothing new: drop valid, keep data/select visible.
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset discards any held word.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
`ifdef MUX_PKT_LOCK_EN
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            last_q    <= 1'b0;
`endif
        end else begin
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
`ifdef MUX_PKT_LOCK_EN
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            last_q    <= last_d;
`endif
        end
    end

    assign bus.Data_Out   = data_q;
    assign bus.Valid_Out  = valid_q;
    assign bus.Select_Out = sel_q;
`ifdef MUX_PKT_LOCK_EN
    assign bus.Last_Out   = last_q;
`endif

endmodule
